// File: rtl/voice_allocator_if.sv
// Note-event request channel: one note-on/note-off per valid/ready handshake.
interface voice_allocator_if #(
    parameter int NOTE_BITS     = 7,
    parameter int FREQ_RES_BITS = 16,
    parameter int VOLUME_BITS   = 8
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_on;
    logic [NOTE_BITS-1:0]     req_note;
    logic [FREQ_RES_BITS-1:0] req_freq;
    logic [VOLUME_BITS-1:0]   req_vel;

    modport master (output req_valid, req_on, req_note, req_freq, req_vel, input req_ready);
    modport slave  (input req_valid, req_on, req_note, req_freq, req_vel, output req_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note events onto NUM_VOICES voice slots
// (retrigger > free > oldest releasing > oldest active steal) and holds
// released voices busy for RELEASE_SAMPLES sample ticks.
module voice_allocator #(
    parameter int NUM_VOICES      = 4,
    parameter int FREQ_RES_BITS   = 16,
    parameter int VOLUME_BITS     = 8,
    parameter int NOTE_BITS       = 7,
    parameter int RELEASE_SAMPLES = 300
) (
    input  logic                                       mclk,
    input  logic                                       rst,
    input  logic                                       pblrc,
    voice_allocator_if.slave                           req,
    output logic [NUM_VOICES-1:0]                      voice_gate,
    output logic [NUM_VOICES-1:0][FREQ_RES_BITS-1:0]   voice_freq,
    output logic [NUM_VOICES-1:0][VOLUME_BITS-1:0]     voice_volume,
    output logic                                       steal
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = $clog2(RELEASE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {V_FREE = 2'd0, V_ACTIVE = 2'd1, V_RELEASE = 2'd2} vstate_t;
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, GATE} fsm_t;

    fsm_t                                 state;
    vstate_t                              vst [NUM_VOICES];
    logic [NUM_VOICES-1:0][NOTE_BITS-1:0] note;
    logic [NUM_VOICES-1:0][CNT_W-1:0]     rel_cnt;
    logic [NUM_VOICES-1:0][IDX_W-1:0]     age;

    // latched event
    logic                     ev_on;
    logic [NOTE_BITS-1:0]     ev_note;
    logic [FREQ_RES_BITS-1:0] ev_freq;
    logic [VOLUME_BITS-1:0]   ev_vel;

    // scan cursor and accumulated candidates
    logic [IDX_W-1:0] scan_idx;
    logic             m_found, f_found, r_found, a_found;
    logic [IDX_W-1:0] m_idx, f_idx, r_idx, a_idx;
    logic [IDX_W-1:0] tgt_idx;

    logic             pblrc_d;
    logic             tick;
    logic [IDX_W-1:0] on_tgt;
    logic             on_steal;

    assign req.req_ready = (state == IDLE);
    assign tick          = pblrc & ~pblrc_d;

    // Remember last pblrc level so only its rising edge counts as a sample tick.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) pblrc_d <= 1'b0;
        else     pblrc_d <= pblrc;
    end

    // Note-on target selection from the accumulated candidates.
    always_comb begin
        on_tgt   = a_idx;
        on_steal = 1'b1;
        if (m_found) begin
            on_tgt   = m_idx;
            on_steal = 1'b0;
        end else if (f_found) begin
            on_tgt   = f_idx;
            on_steal = 1'b0;
        end else if (r_found) begin
            on_tgt   = r_idx;
            on_steal = 1'b0;
        end
    end

    // Controller FSM plus voice bank; release countdown runs every cycle and
    // COMMIT writes are placed after it so they win on the target voice.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            scan_idx     <= '0;
            ev_on        <= 1'b0;
            ev_note      <= '0;
            ev_freq      <= '0;
            ev_vel       <= '0;
            m_found      <= 1'b0;
            f_found      <= 1'b0;
            r_found      <= 1'b0;
            a_found      <= 1'b0;
            m_idx        <= '0;
            f_idx        <= '0;
            r_idx        <= '0;
            a_idx        <= '0;
            tgt_idx      <= '0;
            steal        <= 1'b0;
            voice_gate   <= '0;
            voice_freq   <= '0;
            voice_volume <= '0;
            note         <= '0;
            rel_cnt      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vst[i] <= V_FREE;
                age[i] <= IDX_W'(i);
            end
        end else begin
            steal <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (tick && vst[i] == V_RELEASE) begin
                    if (rel_cnt[i] <= CNT_W'(1)) begin
                        rel_cnt[i] <= '0;
                        vst[i]     <= V_FREE;
                    end else begin
                        rel_cnt[i] <= rel_cnt[i] - CNT_W'(1);
                    end
                end
            end
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        ev_on    <= req.req_on;
                        ev_note  <= req.req_note;
                        ev_freq  <= req.req_freq;
                        ev_vel   <= req.req_vel;
                        scan_idx <= '0;
                        m_found  <= 1'b0;
                        f_found  <= 1'b0;
                        r_found  <= 1'b0;
                        a_found  <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (vst[scan_idx] != V_FREE && note[scan_idx] == ev_note && !m_found) begin
                        m_found <= 1'b1;
                        m_idx   <= scan_idx;
                    end
                    if (vst[scan_idx] == V_FREE && !f_found) begin
                        f_found <= 1'b1;
                        f_idx   <= scan_idx;
                    end
                    if (vst[scan_idx] == V_RELEASE && (!r_found || age[scan_idx] > age[r_idx])) begin
                        r_found <= 1'b1;
                        r_idx   <= scan_idx;
                    end
                    if (vst[scan_idx] == V_ACTIVE && (!a_found || age[scan_idx] > age[a_idx])) begin
                        a_found <= 1'b1;
                        a_idx   <= scan_idx;
                    end
                    if (scan_idx == LAST_IDX) state <= COMMIT;
                    else                      scan_idx <= scan_idx + IDX_W'(1);
                end
                COMMIT: begin
                    tgt_idx <= on_tgt;
                    if (ev_on) begin
                        voice_freq[on_tgt]   <= ev_freq;
                        voice_volume[on_tgt] <= ev_vel;
                        note[on_tgt]         <= ev_note;
                        vst[on_tgt]          <= V_ACTIVE;
                        rel_cnt[on_tgt]      <= '0;
                        voice_gate[on_tgt]   <= 1'b0;
                        steal                <= on_steal;
                        for (int j = 0; j < NUM_VOICES; j++)
                            if (age[j] < age[on_tgt]) age[j] <= age[j] + IDX_W'(1);
                        age[on_tgt] <= '0;
                    end else if (m_found && vst[m_idx] == V_ACTIVE) begin
                        voice_gate[m_idx] <= 1'b0;
                        vst[m_idx]        <= V_RELEASE;
                        rel_cnt[m_idx]    <= REL_LOAD;
                    end
                    state <= GATE;
                end
                GATE: begin
                    if (ev_on) voice_gate[tgt_idx] <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios with literal expectations,
// then randomized events/ticks/resets against a recency-list reference model.
module tb_voice_allocator;
    localparam int N  = 4;
    localparam int RS = 8;
    localparam int FB = 16;
    localparam int VB = 8;
    localparam int NB = 7;
    localparam int FREE = 0, ACT = 1, REL = 2;

    logic mclk  = 1'b0;
    logic rst   = 1'b0;
    logic pblrc = 1'b0;
    logic [N-1:0]         voice_gate;
    logic [N-1:0][FB-1:0] voice_freq;
    logic [N-1:0][VB-1:0] voice_volume;
    logic                 steal;

    voice_allocator_if #(.NOTE_BITS(NB), .FREQ_RES_BITS(FB), .VOLUME_BITS(VB)) req_if ();

    voice_allocator #(
        .NUM_VOICES(N), .FREQ_RES_BITS(FB), .VOLUME_BITS(VB),
        .NOTE_BITS(NB), .RELEASE_SAMPLES(RS)
    ) dut (
        .mclk(mclk), .rst(rst), .pblrc(pblrc), .req(req_if),
        .voice_gate(voice_gate), .voice_freq(voice_freq),
        .voice_volume(voice_volume), .steal(steal)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Voice ages come from a recency list: order[0] newest, order[N-1] oldest.
    int             order[$];
    int             m_st[N], m_cnt[N], m_note[N], snap_st[N];
    logic [N-1:0]   m_gate;
    logic [FB-1:0]  m_freq[N];
    logic [VB-1:0]  m_vol[N];
    logic           m_steal, m_pb, m_tick;
    int             since;   // cycles since handshake, 0 = idle
    logic           e_on;
    int             e_note, tgt, mt, fr, ro, ao;
    logic [FB-1:0]  e_freq;
    logic [VB-1:0]  e_vel;

    always @(posedge mclk or posedge rst) begin
        if (rst) begin
            order = {};
            for (int i = 0; i < N; i++) begin
                order.push_back(i);
                m_st[i] = FREE; m_cnt[i] = 0; m_note[i] = 0;
                m_freq[i] = '0; m_vol[i] = '0;
            end
            m_gate = '0; m_steal = 1'b0; m_pb = 1'b0; since = 0; tgt = 0;
        end else begin
            m_tick  = pblrc && !m_pb;
            m_pb    = pblrc;
            m_steal = 1'b0;
            if (since >= 1 && since <= N) snap_st[since-1] = m_st[since-1];
            for (int i = 0; i < N; i++)
                if (m_tick && m_st[i] == REL) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) m_st[i] = FREE;
                end
            if (since == 0) begin
                if (req_if.req_valid) begin
                    e_on = req_if.req_on; e_note = int'(req_if.req_note);
                    e_freq = req_if.req_freq; e_vel = req_if.req_vel;
                    since = 1;
                end
            end else if (since <= N) begin
                since++;
            end else if (since == N + 1) begin
                mt = -1; fr = -1; ro = -1; ao = -1;
                for (int i = N - 1; i >= 0; i--) begin
                    if (snap_st[i] != FREE && m_note[i] == e_note) mt = i;
                    if (snap_st[i] == FREE) fr = i;
                end
                for (int p = N - 1; p >= 0; p--) begin
                    if (ro < 0 && snap_st[order[p]] == REL) ro = order[p];
                    if (ao < 0 && snap_st[order[p]] == ACT) ao = order[p];
                end
                if (e_on) begin
                    tgt = (mt >= 0) ? mt : (fr >= 0) ? fr : (ro >= 0) ? ro : ao;
                    m_steal = (mt < 0 && fr < 0 && ro < 0);
                    m_freq[tgt] = e_freq; m_vol[tgt] = e_vel; m_note[tgt] = e_note;
                    m_st[tgt] = ACT; m_cnt[tgt] = 0; m_gate[tgt] = 1'b0;
                    for (int p = 0; p < order.size(); p++)
                        if (order[p] == tgt) begin order.delete(p); break; end
                    order.push_front(tgt);
                end else if (mt >= 0 && snap_st[mt] == ACT) begin
                    m_gate[mt] = 1'b0; m_st[mt] = REL; m_cnt[mt] = RS;
                end
                since++;
            end else begin
                if (e_on) m_gate[tgt] = 1'b1;
                since = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge mclk) begin
        chk("gate", 64'(voice_gate), 64'(m_gate));
        chk("steal", 64'(steal), 64'(m_steal));
        chk("ready", 64'(req_if.req_ready), 64'(since == 0));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("freq[%0d]", i), 64'(voice_freq[i]), 64'(m_freq[i]));
            chk($sformatf("vol[%0d]", i), 64'(voice_volume[i]), 64'(m_vol[i]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge mclk);
        #1;
    endtask

    task automatic tick_pb(input int n);
        for (int k = 0; k < n; k++) begin
            step(); pblrc = 1'b1;
            step(); pblrc = 1'b0;
        end
    endtask

    task automatic send(input logic on, input int nt, input int fq, input int vl, input int watch,
                        output int lat, output int nst, output int nlow);
        int tries;
        step();
        req_if.req_on = on; req_if.req_note = NB'(nt);
        req_if.req_freq = FB'(fq); req_if.req_vel = VB'(vl);
        req_if.req_valid = 1'b1;
        tries = 0; lat = 0; nst = 0; nlow = 0;
        while (!req_if.req_ready && tries < 50) begin step(); tries++; end
        if (!req_if.req_ready) begin
            checks++; errors++;
            $display("FAIL hs_timeout: ready stayed 0, required 1");
            req_if.req_valid = 1'b0;
            return;
        end
        @(posedge mclk);
        do begin
            @(negedge mclk);
            lat++;
            if (steal) nst++;
            if (!voice_gate[watch]) nlow++;
            #1 req_if.req_valid = 1'b0;
        end while (!req_if.req_ready && lat < 50);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gate"}, 64'(voice_gate), 0);
        chk({tag, "_steal"}, 64'(steal), 0);
        chk({tag, "_ready"}, 64'(req_if.req_ready), 1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_freq%0d", tag, i), 64'(voice_freq[i]), 0);
            chk($sformatf("%s_vol%0d", tag, i), 64'(voice_volume[i]), 0);
            chk($sformatf("%s_vst%0d", tag, i), 64'(dut.vst[i]), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat, nst, nlow;
        int notes[4];
        logic hs_pending;
        notes = '{60, 62, 64, 67};
        req_if.req_valid = 1'b0; req_if.req_on = 1'b0;
        req_if.req_note = '0; req_if.req_freq = '0; req_if.req_vel = '0;
        #1 rst = 1'b1;
        repeat (3) step();
        chk_zero("rst");
        rst = 1'b0;

        // fill all four voices
        for (int k = 0; k < 4; k++) begin
            send(1'b1, notes[k], 1000 + notes[k], notes[k], k, lat, nst, nlow);
            chk($sformatf("lat_on%0d", k), 64'(lat), 7);
            chk($sformatf("steal_on%0d", k), 64'(nst), 0);
        end
        chk("gate_full", 64'(voice_gate), 4'b1111);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("freq_fill%0d", k), 64'(voice_freq[k]), 64'(1000 + notes[k]));
            chk($sformatf("vol_fill%0d", k), 64'(voice_volume[k]), 64'(notes[k]));
            chk($sformatf("age_fill%0d", k), 64'(dut.age[k]), 64'(3 - k));
        end

        // fifth note steals the oldest voice (0)
        send(1'b1, 69, 1069, 77, 0, lat, nst, nlow);
        chk("steal_cnt", 64'(nst), 1);
        chk("steal_gate0_low", 64'(nlow), 1);
        chk("steal_freq0", 64'(voice_freq[0]), 1069);
        chk("steal_gate", 64'(voice_gate), 4'b1111);

        // note-off 62 releases voice 1; a new note takes it before it frees
        send(1'b0, 62, 0, 0, 1, lat, nst, nlow);
        chk("off62_gate", 64'(voice_gate), 4'b1101);
        chk("off62_vst1", 64'(dut.vst[1]), REL);
        tick_pb(3);
        send(1'b1, 71, 1071, 50, 1, lat, nst, nlow);
        chk("on71_steal", 64'(nst), 0);
        chk("on71_gate1_low", 64'(nlow), 6);
        chk("on71_freq1", 64'(voice_freq[1]), 1071);
        chk("on71_gate", 64'(voice_gate), 4'b1111);

        // release countdown: free after exactly RS ticks
        send(1'b0, 71, 0, 0, 1, lat, nst, nlow);
        tick_pb(RS - 1);
        chk("rel_still", 64'(dut.vst[1]), REL);
        tick_pb(1);
        chk("rel_free", 64'(dut.vst[1]), FREE);
        chk("rel_freq_hold", 64'(voice_freq[1]), 1071);

        // retrigger 64 on voice 2
        send(1'b1, 64, 2064, 99, 2, lat, nst, nlow);
        chk("retrig_steal", 64'(nst), 0);
        chk("retrig_low", 64'(nlow), 1);
        chk("retrig_freq2", 64'(voice_freq[2]), 2064);
        chk("retrig_vol2", 64'(voice_volume[2]), 99);
        chk("retrig_gate", 64'(voice_gate), 4'b1101);

        // note-off for a note not playing
        send(1'b0, 50, 0, 0, 0, lat, nst, nlow);
        chk("off50_lat", 64'(lat), 7);
        chk("off50_gate", 64'(voice_gate), 4'b1101);

        // reset during SCAN
        step();
        req_if.req_on = 1'b1; req_if.req_note = NB'(80);
        req_if.req_freq = FB'(1080); req_if.req_vel = VB'(8); req_if.req_valid = 1'b1;
        step(); req_if.req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk_zero("rst_scan");
        rst = 1'b0;
        send(1'b1, 40, 1040, 40, 0, lat, nst, nlow);
        chk("post_rst_gate", 64'(voice_gate), 4'b0001);
        chk("post_rst_freq0", 64'(voice_freq[0]), 1040);

        // reset during release countdown
        send(1'b0, 40, 0, 0, 0, lat, nst, nlow);
        tick_pb(2);
        rst = 1'b1;
        step();
        chk_zero("rst_rel");
        rst = 1'b0;
        send(1'b1, 41, 1041, 41, 0, lat, nst, nlow);
        chk("post_rst2_gate", 64'(voice_gate), 4'b0001);
        chk("post_rst2_freq0", 64'(voice_freq[0]), 1041);

        // randomized phase
        hs_pending = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 2) == 0) pblrc = ~pblrc;
            if (hs_pending) begin req_if.req_valid = 1'b0; hs_pending = 1'b0; end
            if (!req_if.req_valid && $urandom_range(0, 2) == 0) begin
                req_if.req_on   = ($urandom_range(0, 1) == 1);
                req_if.req_note = NB'($urandom_range(60, 66));
                req_if.req_freq = FB'($urandom);
                req_if.req_vel  = VB'($urandom);
                req_if.req_valid = 1'b1;
            end
            if (req_if.req_valid && req_if.req_ready) hs_pending = 1'b1;
        end
        rst = 1'b0;
        req_if.req_valid = 1'b0;
        repeat (20) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic note scheduler that sits between the note-event source (MIDI/PS register front end) and a bank of `NUM_VOICES` enveloped oscillator voices (triangle/sine sources feeding the mixer). It accepts note-on/note-off events over a valid/ready handshake and assigns each note-on to a voice slot: retrigger of the same note first, then a free voice, then stealing the oldest voice. Per voice it drives gate, frequency word and volume. It holds released voices busy for a fixed number of audio samples so their decay can finish.

## Interface
- `NUM_VOICES`, 4: voice slots; power of two, 2–16.
- `FREQ_RES_BITS`, 16: width of the frequency word passed to a voice.
- `VOLUME_BITS`, 8: width of the volume/velocity word.
- `NOTE_BITS`, 7: width of the note number used for matching.
- `RELEASE_SAMPLES`, 300: pblrc periods a voice stays in RELEASE before it becomes FREE; ≥1.

Ports:
- `mclk` in 1: master clock (256× sample rate); single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `pblrc` in 1: sample-rate clock, synchronous to `mclk`; only its rising edge is used (one-cycle tick).
- `req_valid` in 1: event present.
- `req_ready` out 1: allocator can accept an event.
- `req_on` in 1: 1 = note-on, 0 = note-off.
- `req_note` in NOTE_BITS: note number.
- `req_freq` in FREQ_RES_BITS: frequency word (note-on only).
- `req_vel` in VOLUME_BITS: velocity, which becomes the voice volume (note-on only).
- `voice_gate` out NUM_VOICES: per-voice gate.
- `voice_freq` out NUM_VOICES×FREQ_RES_BITS: per-voice frequency word.
- `voice_volume` out NUM_VOICES×VOLUME_BITS: per-voice volume.
- `steal` out 1: one-cycle pulse when a note-on takes an ACTIVE voice playing a different note.

## Operation
- Per-voice state: FREE, ACTIVE or RELEASE. Each voice also holds a note register, a release counter and an age rank.
- Age ranks always form a permutation of 0..N-1: 0 is the newest allocation and N-1 the oldest. At reset, `age[i]=i`.
- On allocation to voice k, every voice whose age is below k's old age increments, and k's age becomes 0.
- Controller FSM has four states: IDLE, SCAN, COMMIT, GATE.
- `req_ready` = (state == IDLE).
- A handshake (`req_valid && req_ready`) latches `req_on/note/freq/vel` and moves to SCAN.
- SCAN visits one voice per cycle, index 0..N-1 ascending, and accumulates four candidates:
  - match: first non-FREE voice with the same note;
  - free: first FREE voice;
  - oldest RELEASE voice (highest age);
  - oldest ACTIVE voice (highest age).
- After index N-1 the FSM goes to COMMIT.
- Note-on target priority: match, then free, then oldest RELEASE, then oldest ACTIVE (`steal`=1 only in the last case).
- Note-on COMMIT on target k:
  - write freq, volume and note; state becomes ACTIVE; update age;
  - `voice_gate[k]` forced 0 this cycle.
- Note-on GATE: `voice_gate[k]` set to 1. Every allocation therefore gives the envelope a low-then-high edge, including retrigger and steal.
- Note-off COMMIT:
  - if match exists and is ACTIVE: gate 0, state becomes RELEASE, release counter loads `RELEASE_SAMPLES`;
  - otherwise the event is dropped with no change.
- Note-off GATE: no-op.
- GATE always returns to IDLE.
- Release counters run independently of the FSM. On each pblrc rising-edge tick, every RELEASE voice decrements; a voice whose counter reaches 0 becomes FREE.
- `voice_freq` and `voice_volume` hold through RELEASE and FREE. They change only on note-on COMMIT.

## Timing
- Handshake at cycle 0; SCAN covers cycles 1..N; COMMIT is cycle N+1; GATE is cycle N+2; IDLE and `req_ready`=1 at cycle N+3.
- Maximum throughput: one event per N+3 cycles.
- All outputs are registered. COMMIT register writes are visible at cycle N+2, and the gate rises visibly at N+3.
- `steal` is high for exactly the cycle after COMMIT.
- Reset values while `rst` is high and after release:
  - `voice_gate`=0, `voice_freq`=0, `voice_volume`=0, `steal`=0;
  - all voices FREE, release counters 0, ages i, FSM in IDLE.
- `req_ready` reads 1 during reset, but no handshake is taken while `rst`=1.
- Reset mid-operation: the event in progress is discarded and all state returns to reset values.
- Tick versus SCAN: candidate classification uses the state sampled at each voice's scan cycle.
- Tick in the COMMIT cycle for the target voice: the COMMIT write wins and the voice ends ACTIVE.
- Tick in the COMMIT cycle for other voices: they decrement normally.
- Note-off COMMIT together with a tick: the counter loads `RELEASE_SAMPLES`, not `RELEASE_SAMPLES-1`.

## Test plan
Bench parameters: N=4, RELEASE_SAMPLES=8.
- Reset, then note-on notes 60,62,64,67 → voices 0,1,2,3 ACTIVE with the requested freq/vel, gates 4'b1111, `steal`=0. Ages read 3,2,1,0, and `req_ready` recovers 7 cycles after each handshake.
- Fifth note-on 69 with all voices ACTIVE → voice 0 (the oldest) is stolen. `steal` pulses once, gate[0] is 0 for one cycle then 1, and freq[0] takes the new word.
- Note-off 62 → gate[1]=0, voice 1 in RELEASE. Exactly 8 pblrc rising edges later it is FREE. Note-on 71 before then takes voice 1 over the ACTIVE voices, with `steal`=0.
- Note-on 64 while 64 is already ACTIVE on voice 2 → retrigger on voice 2 (gate 1→0→1), no other voice changes, `steal`=0.
- Note-off 50 (not playing) → no output change, and `req_ready` returns at N+3.
- Assert `rst` during SCAN of a note-on, and separately during a release countdown → all outputs 0 and all voices FREE immediately. The first note-on after reset lands on voice 0.
